alu_pipe: RTL

Parametrised, fully pipelined ALU that replaces the fixed 2-stage 4-op ALU. Adds a valid/ready handshake with backpressure, configurable pipeline depth, an 8-op set (adds MUL, arithmetic SHR, AND, OR) and a status-flag output. It sits between an operand sequencer (upstream) and a result consumer (downstream) and accepts one operation per cycle when unstalled.

---
 rtl/alu_pipe.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Pipelined 8-op ALU with valid/ready backpressure and {V,N,Z} flags.
// Define ALU_SAT_EN to clamp ADD/SUB results to the DATAW signed range.
module alu_pipe #(
  parameter int DATAW       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATAW-1:0]     i_dataa,
  input  logic [DATAW-1:0]     i_datab,
  input  logic [2:0]           i_op,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*DATAW-1:0]   o_result,
  output logic [2:0]           o_flags
);

  localparam int W2 = 2 * DATAW;
  localparam logic [W2-1:0] SH_LIM = W2'(W2);
  localparam logic [W2-1:0] S_MAX  = {{(DATAW+1){1'b0}}, {(DATAW-1){1'b1}}};
  localparam logic [W2-1:0] S_MIN  = {{(DATAW+1){1'b1}}, {(DATAW-1){1'b0}}};

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  // Exact result does not fit DATAW signed bits when the upper bits are not all sign copies.
  function automatic logic ovf(input logic signed [W2-1:0] x);
    return !((&x[W2-1:DATAW-1]) || !(|x[W2-1:DATAW-1]));
  endfunction

  function automatic logic [W2-1:0] sat(input logic signed [W2-1:0] x);
    if (!ovf(x)) return x;
    return x[W2-1] ? S_MIN : S_MAX;
  endfunction

  logic signed [W2-1:0] a_sx, b_sx, sum_p0, dif_p0, prd_p0;
  logic [W2-1:0]        a_zx, b_zx, res_p0;
  logic [2:0]           flg_p0;
  logic                 v_p0;

  // ---- stage 0: combinational compute ----
  always_comb begin
    a_sx   = {{DATAW{i_dataa[DATAW-1]}}, i_dataa};
    b_sx   = {{DATAW{i_datab[DATAW-1]}}, i_datab};
    a_zx   = {{DATAW{1'b0}}, i_dataa};
    b_zx   = {{DATAW{1'b0}}, i_datab};
    sum_p0 = a_sx + b_sx;
    dif_p0 = a_sx - b_sx;
    prd_p0 = a_sx * b_sx;
    res_p0 = '0;
    v_p0   = 1'b0;
    case (i_op)
      OP_SHL: begin
        if (b_zx >= SH_LIM) res_p0 = '0;
        else                res_p0 = a_zx << b_zx;
      end
      OP_ADD: begin
        v_p0 = ovf(sum_p0);
`ifdef ALU_SAT_EN
        res_p0 = sat(sum_p0);
`else
        res_p0 = sum_p0;
`endif
      end
      OP_SUB: begin
        v_p0 = ovf(dif_p0);
`ifdef ALU_SAT_EN
        res_p0 = sat(dif_p0);
`else
        res_p0 = dif_p0;
`endif
      end
      OP_MUL: begin
        v_p0   = ovf(prd_p0);
        res_p0 = prd_p0;
      end
      OP_SHR: begin
        if (b_zx >= SH_LIM) res_p0 = {W2{i_dataa[DATAW-1]}};
        else                res_p0 = a_sx >>> b_zx;
      end
      OP_AND:  res_p0 = a_zx & b_zx;
      OP_OR:   res_p0 = a_zx | b_zx;
      OP_CLR:  res_p0 = '0;
      default: res_p0 = '0;
    endcase
    flg_p0 = {v_p0, res_p0[W2-1], (res_p0 == '0)};
  end

  logic                   adv;
  logic [PIPE_STAGES-1:0] vld_d, vld_q;
  logic [W2-1:0]          tail_res;
  logic [2:0]             tail_flg;
  logic                   tail_vld;

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  assign o_valid = vld_q[PIPE_STAGES-1];

  always_comb begin
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = i_valid;
      for (int s = 1; s < PIPE_STAGES; s++) vld_d[s] = vld_q[s-1];
    end
  end

  // ---- stages 1..PIPE_STAGES-1: delay line feeding the output register ----
  generate
    if (PIPE_STAGES > 1) begin : g_dly
      logic [W2-1:0] res_d [PIPE_STAGES-1];
      logic [W2-1:0] res_q [PIPE_STAGES-1];
      logic [2:0]    flg_d [PIPE_STAGES-1];
      logic [2:0]    flg_q [PIPE_STAGES-1];

      always_comb begin
        res_d = res_q;
        flg_d = flg_q;
        if (adv) begin
          res_d[0] = res_p0;
          flg_d[0] = flg_p0;
          for (int s = 1; s < PIPE_STAGES - 1; s++) begin
            res_d[s] = res_q[s-1];
            flg_d[s] = flg_q[s-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        res_q <= res_d;
        flg_q <= flg_d;
      end

      assign tail_res = res_q[PIPE_STAGES-2];
      assign tail_flg = flg_q[PIPE_STAGES-2];
      assign tail_vld = vld_q[PIPE_STAGES-2];
    end else begin : g_nodly
      assign tail_res = res_p0;
      assign tail_flg = flg_p0;
      assign tail_vld = i_valid;
    end
  endgenerate

  logic [W2-1:0] res_out_d, res_out_q;
  logic [2:0]    flg_out_d, flg_out_q;

  // ---- final stage: output register, keeps last value across bubbles ----
  always_comb begin
    res_out_d = res_out_q;
    flg_out_d = flg_out_q;
    if (adv && tail_vld) begin
      res_out_d = tail_res;
      flg_out_d = tail_flg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      res_out_q <= '0;
      flg_out_q <= '0;
    end else begin
      vld_q     <= vld_d;
      res_out_q <= res_out_d;
      flg_out_q <= flg_out_d;
    end
  end

  assign o_result = res_out_q;
  assign o_flags  = flg_out_q;

endmodule
